// File: rtl/peridot_phy_rxd.sv
// UART receiver PHY: 8N1 deframing (LSB first) into an Avalon-ST source with a one-entry buffer.
// Optional PERIDOT_PHY_RXD_MAJORITY_EN: 2-of-3 majority sampling around each bit centre.
module peridot_phy_rxd #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int UART_BAUDRATE   = 115200
) (
  input  logic       clock_sig,
  input  logic       reset_sig,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_error,
  output logic       out_overrun,
  input  logic       rxd
);

  localparam int          DIV_FULL = CLOCK_FREQUENCY / UART_BAUDRATE - 1;
  localparam logic [11:0] DIVNUM   = DIV_FULL[11:0];
  localparam logic [11:0] HALFNUM  = {1'b0, DIVNUM[11:1]};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic [1:0]  state_q, state_d;
  logic        armed_q, armed_d;
  logic [11:0] divcount_q, divcount_d;
  logic [3:0]  bitcount_q, bitcount_d;
  logic [7:0]  shift_q, shift_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_error_q, out_error_d;
  logic        out_overrun_q, out_overrun_d;

  logic rxd_s;
  logic at_zero;
  logic sample_tick;
  logic sample_val;
  logic complete;

`ifdef PERIDOT_PHY_RXD_MAJORITY_EN
  logic maj_s1_q, maj_s1_d;
  logic maj_s0_q, maj_s0_d;
  logic maj_pend_q, maj_pend_d;
`endif

  assign rxd_s   = sync2_q;
  assign at_zero = (divcount_q == 12'd0);

  // NOTE: every _d gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    sync1_d       = rxd;
    sync2_d       = sync1_q;
    state_d       = state_q;
    armed_d       = armed_q;
    divcount_d    = divcount_q;
    bitcount_d    = bitcount_q;
    shift_d       = shift_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_error_d   = out_error_q;
    out_overrun_d = 1'b0;
    complete      = 1'b0;

    if (state_q != ST_IDLE) begin
      divcount_d = at_zero ? DIVNUM : divcount_q - 12'd1;
    end

`ifdef PERIDOT_PHY_RXD_MAJORITY_EN
    // Votes are gathered at divcount 1 and 0; the third vote is the live line one cycle later.
    maj_s1_d   = maj_s1_q;
    maj_s0_d   = maj_s0_q;
    maj_pend_d = (state_q != ST_IDLE) && at_zero;
    if ((state_q != ST_IDLE) && (divcount_q == 12'd1)) maj_s1_d = rxd_s;
    if ((state_q != ST_IDLE) && at_zero)               maj_s0_d = rxd_s;
    sample_tick = maj_pend_q;
    sample_val  = (maj_s1_q & maj_s0_q) | (maj_s1_q & rxd_s) | (maj_s0_q & rxd_s);
`else
    sample_tick = (state_q != ST_IDLE) && at_zero;
    sample_val  = rxd_s;
`endif

    case (state_q)
      ST_IDLE: begin
        // A start is only accepted after the line has been seen high.
        if (armed_q && !rxd_s) begin
          divcount_d = HALFNUM;
          armed_d    = 1'b0;
          state_d    = ST_START;
        end else if (rxd_s) begin
          armed_d = 1'b1;
        end
      end
      ST_START: begin
        if (sample_tick) begin
          if (sample_val) begin
            state_d = ST_IDLE;
          end else begin
            bitcount_d = 4'd8;
            state_d    = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (sample_tick) begin
          shift_d    = {sample_val, shift_q[7:1]};
          bitcount_d = bitcount_q - 4'd1;
          if (bitcount_q == 4'd1) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Back to IDLE at the stop-bit centre so a following start edge is caught in time.
        if (sample_tick) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (complete) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_data_d  = shift_q;
        out_error_d = ~sample_val;
      end else begin
        out_overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      state_q       <= ST_IDLE;
      armed_q       <= 1'b0;
      divcount_q    <= 12'd0;
      bitcount_q    <= 4'd0;
      shift_q       <= 8'h00;
      out_valid_q   <= 1'b0;
      out_data_q    <= 8'h00;
      out_error_q   <= 1'b0;
      out_overrun_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      state_q       <= state_d;
      armed_q       <= armed_d;
      divcount_q    <= divcount_d;
      bitcount_q    <= bitcount_d;
      shift_q       <= shift_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_error_q   <= out_error_d;
      out_overrun_q <= out_overrun_d;
    end
  end

`ifdef PERIDOT_PHY_RXD_MAJORITY_EN
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      maj_s1_q   <= 1'b1;
      maj_s0_q   <= 1'b1;
      maj_pend_q <= 1'b0;
    end else begin
      maj_s1_q   <= maj_s1_d;
      maj_s0_q   <= maj_s0_d;
      maj_pend_q <= maj_pend_d;
    end
  end
`endif

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_error   = out_error_q;
  assign out_overrun = out_overrun_q;

endmodule

// File: tb/tb_peridot_phy_rxd.sv
// Bench for peridot_phy_rxd at 50 MHz / 115200 baud: frames are generated bit by bit and every
// accepted beat is compared against a queue of {error, byte} expectations built from the frames sent.
module tb_peridot_phy_rxd;

  localparam int BIT_CLKS = 434;

  logic       clock_sig = 1'b0;
  logic       reset_sig = 1'b1;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_error;
  logic       out_overrun;
  logic       rxd = 1'b1;

  int vectors     = 0;
  int miscompares = 0;
  int beats       = 0;
  int exp_beats   = 0;
  int ovr_cycles  = 0;
  int ovr_long    = 0;
  logic ovr_prev  = 1'b0;
  logic [8:0] exp_q[$];

  peridot_phy_rxd #(.CLOCK_FREQUENCY(50000000), .UART_BAUDRATE(115200)) dut (
    .clock_sig  (clock_sig),
    .reset_sig  (reset_sig),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_error  (out_error),
    .out_overrun(out_overrun),
    .rxd        (rxd)
  );

  always #10 clock_sig = ~clock_sig;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Beat monitor: every handshake must match the oldest outstanding expectation.
  always @(negedge clock_sig) begin
    if (!reset_sig) begin
      if (out_valid && out_ready) begin
        beats++;
        chk("beat_was_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("beat_error_data", {23'd0, out_error, out_data}, {23'd0, exp_q.pop_front()});
      end
      if (out_overrun) begin
        ovr_cycles++;
        if (ovr_prev) ovr_long++;
      end
      ovr_prev = out_overrun;
    end
  end

  task automatic clocks(input int n);
    repeat (n) begin
      @(posedge clock_sig);
      #1;
    end
  endtask

  task automatic bit_time(input logic v, input logic spike);
    for (int c = 0; c < BIT_CLKS; c++) begin
      rxd = (spike && c == BIT_CLKS / 2) ? ~v : v;
      @(posedge clock_sig);
      #1;
    end
    rxd = v;
  endtask

  // Sends one 8N1 frame; when expected, the reference {error, byte} is queued first.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic expected);
    logic spike;
`ifdef PERIDOT_PHY_RXD_MAJORITY_EN
    spike = 1'b1;
`else
    spike = 1'b0;
`endif
    if (expected) begin
      exp_q.push_back({~stop, b});
      exp_beats++;
    end
    bit_time(1'b0, spike);
    for (int i = 0; i < 8; i++) bit_time(b[i], spike);
    bit_time(stop, spike);
  endtask

  task automatic check_drained(input string tag);
    @(negedge clock_sig);
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_beat_count"}, 32'(beats), 32'(exp_beats));
    @(posedge clock_sig);
    #1;
  endtask

  initial begin
    logic [7:0] rb;
    logic [7:0] b99;

    // Reset state
    clocks(3);
    @(negedge clock_sig);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_error", {31'd0, out_error}, 32'd0);
    chk("rst_overrun", {31'd0, out_overrun}, 32'd0);
    @(posedge clock_sig);
    #1;
    reset_sig = 1'b0;
    clocks(BIT_CLKS);

    // Single 0x55
    send_frame(8'h55, 1'b1, 1'b1);
    check_drained("byte55");
    clocks(BIT_CLKS);

    // Back-to-back with no idle
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'hA3, 1'b1, 1'b1);
    check_drained("b2b");
    chk("no_overrun_yet", 32'(ovr_cycles), 32'd0);

    // Framing error, then a long break that must not produce bytes
    send_frame(8'h3C, 1'b0, 1'b1);
    check_drained("framing");
    rxd = 1'b0;
    clocks(20 * BIT_CLKS);
    rxd = 1'b1;
    clocks(2 * BIT_CLKS);
    check_drained("break");

    // Short glitch on idle line is a false start
    rxd = 1'b0;
    clocks(100);
    rxd = 1'b1;
    clocks(2 * BIT_CLKS);
    check_drained("glitch");

    // Overrun: sink stalled, second byte dropped
    out_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b0);
    clocks(BIT_CLKS);
    @(negedge clock_sig);
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_data_held", {24'd0, out_data}, 32'h11);
    chk("overrun_cycles", 32'(ovr_cycles), 32'd1);
    chk("overrun_single_cycle", 32'(ovr_long), 32'd0);
    out_ready = 1'b1;
    @(negedge clock_sig);
    @(negedge clock_sig);
    chk("drained_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clock_sig);
    #1;
    check_drained("overrun");

    // Reset during bit 4 of 0x99
    b99 = 8'h99;
    bit_time(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) bit_time(b99[i], 1'b0);
    rxd = b99[4];
    clocks(150);
    reset_sig = 1'b1;
    clocks(3);
    rxd = 1'b1;
    @(negedge clock_sig);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_data", {24'd0, out_data}, 32'd0);
    chk("midrst_error", {31'd0, out_error}, 32'd0);
    @(posedge clock_sig);
    #1;
    reset_sig = 1'b0;
    clocks(BIT_CLKS);
    send_frame(8'h42, 1'b1, 1'b1);
    check_drained("after_reset");
    clocks(BIT_CLKS);

    // Randomized bytes with random idle gaps
    for (int k = 0; k < 3; k++) begin
      rb = 8'($urandom);
      clocks(int'($urandom_range(0, 300)));
      send_frame(rb, 1'b1, 1'b1);
    end
    check_drained("random");
    clocks(BIT_CLKS);

    @(negedge clock_sig);
    chk("final_overrun_cycles", 32'(ovr_cycles), 32'd1);
    chk("final_beats", 32'(beats), 32'(exp_beats));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
